// File: rtl/busy_tracker.sv
// busy_tracker: request/accept/cancel handshake tracker driving busy, with done/timed_out/dropped pulses
// Optional embedded assertions are compiled when BUSY_TRACKER_SVA_EN is defined.
module busy_tracker #(
  parameter int BUSY_CYCLES = 4,
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic request,
  input  logic accept,
  input  logic cancel,
  output logic busy,
  output logic done,
  output logic timed_out,
  output logic dropped,
  output logic pending
);
  typedef enum logic [1:0] {IDLE, PENDING, BUSY} state_t;
  localparam logic [7:0] BUSY_LIM = 8'(BUSY_CYCLES);
  localparam logic [7:0] WAIT_LIM = 8'(TIMEOUT - 1);
  state_t state, state_n;
  logic [7:0] wait_cnt, wait_n, busy_cnt, busy_n;
  logic done_n, timed_out_n, dropped_n;
  logic take;
  assign take = (state == PENDING) && accept && !cancel;
  assign busy = take || (state == BUSY);
  assign pending = state == PENDING;
  // State, counters and pulse outputs; async reset aborts any transaction silently
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      wait_cnt <= '0;
      busy_cnt <= '0;
      done <= 1'b0;
      timed_out <= 1'b0;
      dropped <= 1'b0;
    end else begin
      state <= state_n;
      wait_cnt <= wait_n;
      busy_cnt <= busy_n;
      done <= done_n;
      timed_out <= timed_out_n;
      dropped <= dropped_n;
    end
  end
  // Next-state logic; busy_cnt holds the count for the current cycle, so the accept cycle (count 1) loads 2 for the first BUSY cycle
  always_comb begin
    state_n = state;
    wait_n = wait_cnt;
    busy_n = busy_cnt;
    done_n = 1'b0;
    timed_out_n = 1'b0;
    dropped_n = request && (state != IDLE);
    case (state)
      IDLE: begin
        if (request) begin
          state_n = PENDING;
          wait_n = '0;
        end
      end
      PENDING: begin
        if (cancel) begin
          state_n = IDLE;
        end else if (accept) begin
          state_n = (BUSY_LIM == 8'd1) ? IDLE : BUSY;
          done_n = BUSY_LIM == 8'd1;
          busy_n = 8'd2;
        end else if (wait_cnt >= WAIT_LIM) begin
          state_n = IDLE;
          timed_out_n = 1'b1;
        end else begin
          wait_n = (wait_cnt == 8'hff) ? wait_cnt : wait_cnt + 8'd1;
        end
      end
      BUSY: begin
        if (busy_cnt >= BUSY_LIM) begin
          state_n = IDLE;
          done_n = 1'b1;
        end else begin
          busy_n = (busy_cnt == 8'hff) ? busy_cnt : busy_cnt + 8'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end
`ifdef BUSY_TRACKER_SVA_EN
  default clocking dcb @(posedge clk); endclocking
  default disable iff (!rst_n);
  a_rose_busy: assert property ($rose(busy) |-> pending && accept && !cancel);
  a_window: assert property ($rose(busy) |-> busy [*BUSY_CYCLES] ##1 (!busy && done));
  a_done_1: assert property (done |=> !done);
  a_to_1: assert property (timed_out |=> !timed_out);
  a_excl: assert property (!(done && timed_out));
  c_accept: cover property (request ##1 (!cancel throughout accept [->1]) ##0 $rose(busy));
`else
`endif
endmodule

// File: tb/tb_busy_tracker.sv
// tb_busy_tracker: directed table, reset corner case and randomized model check for busy_tracker
module tb_busy_tracker;
  logic clk = 1'b0;
  logic rst_n, request, accept, cancel;
  logic busy, done, timed_out, dropped, pending;
  logic busy1, done1, timed_out1, dropped1, pending1;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  busy_tracker #(.BUSY_CYCLES(3), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n), .request(request), .accept(accept), .cancel(cancel),
    .busy(busy), .done(done), .timed_out(timed_out), .dropped(dropped), .pending(pending)
  );

  busy_tracker #(.BUSY_CYCLES(1), .TIMEOUT(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .request(request), .accept(accept), .cancel(cancel),
    .busy(busy1), .done(done1), .timed_out(timed_out1), .dropped(dropped1), .pending(pending1)
  );

  typedef struct {
    logic req, acc, can;
    logic busy, pend, done, to, drop;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input logic rq, ac, cn, b, p, d, t, dr);
    vec_t v;
    v.req = rq; v.acc = ac; v.can = cn;
    v.busy = b; v.pend = p; v.done = d; v.to = t; v.drop = dr;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic b, p, d, t, dr);
    chk({tag, " busy"}, busy, b);
    chk({tag, " pending"}, pending, p);
    chk({tag, " done"}, done, d);
    chk({tag, " timed_out"}, timed_out, t);
    chk({tag, " dropped"}, dropped, dr);
  endtask

  task automatic drive(input logic rq, ac, cn);
    @(negedge clk);
    request = rq; accept = ac; cancel = cn;
    #2;
  endtask

  // transaction-level reference: phase plus timestamps of entry into pending and of acceptance
  int bcs[2] = '{3, 1};
  int tos[2] = '{8, 2};
  int mode[2], pstart[2], acc_at[2];
  logic rdone[2], rto[2], rdrop[2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mode[k] = 0; rdone[k] = 0; rto[k] = 0; rdrop[k] = 0;
    end
  endtask

  task automatic model_step(input int t);
    for (int k = 0; k < 2; k++) begin
      rdone[k] = 0; rto[k] = 0;
      rdrop[k] = request && mode[k] != 0;
      if (mode[k] == 0) begin
        if (request) begin mode[k] = 1; pstart[k] = t + 1; end
      end else if (mode[k] == 1) begin
        if (cancel) mode[k] = 0;
        else if (accept) begin
          acc_at[k] = t;
          if (bcs[k] == 1) begin mode[k] = 0; rdone[k] = 1; end
          else mode[k] = 2;
        end else if (t - pstart[k] + 1 == tos[k]) begin
          mode[k] = 0; rto[k] = 1;
        end
      end else if (t - acc_at[k] + 1 == bcs[k]) begin
        mode[k] = 0; rdone[k] = 1;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; request = 1'b0; accept = 1'b0; cancel = 1'b0;
    // scenario 1: request t0, accept t5
    add(1,0,0, 0,0,0,0,0);
    for (int i = 1; i <= 4; i++) add(0,0,0, 0,1,0,0,0);
    add(0,1,0, 1,1,0,0,0);
    add(0,0,0, 1,0,0,0,0);
    add(0,0,0, 1,0,0,0,0);
    add(0,0,0, 0,0,1,0,0);
    add(0,0,0, 0,0,0,0,0);
    // scenario 2: cancel t2, late accept t3 ignored
    add(1,0,0, 0,0,0,0,0);
    add(0,0,0, 0,1,0,0,0);
    add(0,0,1, 0,1,0,0,0);
    add(0,1,0, 0,0,0,0,0);
    add(0,0,0, 0,0,0,0,0);
    // scenario 3: accept+cancel t4, cancel wins
    add(1,0,0, 0,0,0,0,0);
    for (int i = 1; i <= 3; i++) add(0,0,0, 0,1,0,0,0);
    add(0,1,1, 0,1,0,0,0);
    add(0,0,0, 0,0,0,0,0);
    // scenario 4: no accept, timeout pulse t9
    add(1,0,0, 0,0,0,0,0);
    for (int i = 1; i <= 8; i++) add(0,0,0, 0,1,0,0,0);
    add(0,0,0, 0,0,0,1,0);
    add(0,0,0, 0,0,0,0,0);
    // scenario 5: accept t2, extra request t3 dropped t4
    add(1,0,0, 0,0,0,0,0);
    add(0,0,0, 0,1,0,0,0);
    add(0,1,0, 1,1,0,0,0);
    add(1,0,0, 1,0,0,0,0);
    add(0,0,0, 1,0,0,0,1);
    add(0,0,0, 0,0,1,0,0);
    add(0,0,0, 0,0,0,0,0);
    // request in the done cycle is taken
    add(1,0,0, 0,0,0,0,0);
    add(0,1,0, 1,1,0,0,0);
    add(0,0,0, 1,0,0,0,0);
    add(0,0,0, 1,0,0,0,0);
    add(1,0,0, 0,0,1,0,0);
    add(0,0,1, 0,1,0,0,0);
    add(0,0,0, 0,0,0,0,0);

    #3;
    chk_all("reset", 0, 0, 0, 0, 0);
    @(posedge clk); @(posedge clk);
    @(negedge clk); rst_n = 1'b1;

    foreach (vecs[i])
      begin
        drive(vecs[i].req, vecs[i].acc, vecs[i].can);
        chk_all($sformatf("vec%0d", i), vecs[i].busy, vecs[i].pend, vecs[i].done, vecs[i].to, vecs[i].drop);
      end

    // scenario 6: async reset while busy aborts without done
    drive(1, 0, 0);
    drive(0, 0, 0);
    drive(0, 1, 0);
    chk("rst6 busy_accept", busy, 1'b1);
    drive(0, 0, 0);
    chk("rst6 busy_before", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rst6 busy_async", busy, 1'b0);
    chk("rst6 pending_async", pending, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0);
      chk("rst6 no_done", done, 1'b0);
      chk("rst6 no_busy", busy, 1'b0);
    end
    drive(1, 0, 0);
    drive(0, 1, 0);
    chk("rst6 recover_busy", busy, 1'b1);
    for (int i = 0; i < 3; i++) drive(0, 0, 0);
    chk("rst6 recover_done", done, 1'b1);

    // randomized phase against the reference model, both configurations
    @(negedge clk);
    rst_n = 1'b0; request = 0; accept = 0; cancel = 0;
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    for (int t = 0; t < 3000; t++) begin
      drive(($urandom_range(3) == 0), ($urandom_range(2) == 0), ($urandom_range(7) == 0));
      chk("rnd busy", busy, (mode[0] == 1 && accept && !cancel) || mode[0] == 2);
      chk("rnd pending", pending, mode[0] == 1);
      chk("rnd done", done, rdone[0]);
      chk("rnd timed_out", timed_out, rto[0]);
      chk("rnd dropped", dropped, rdrop[0]);
      chk("rnd1 busy", busy1, mode[1] == 1 && accept && !cancel);
      chk("rnd1 pending", pending1, mode[1] == 1);
      chk("rnd1 done", done1, rdone[1]);
      chk("rnd1 timed_out", timed_out1, rto[1]);
      chk("rnd1 dropped", dropped1, rdrop[1]);
      model_step(t);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
